gray_step_checker: RTL and testbench



---
 rtl/gray_pkg.sv | 40 ++++
 rtl/gray_to_binary.sv | 25 ++
 rtl/gray_step_checker.sv | 145 ++++++++++++++
 tb/tb_gray_step_checker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code checking path.
//   state_t  : tracking state of gray_step_checker (EMPTY, TRACK, FAULT)
//   gray2bin : Gray-to-binary decode, width-generic via zero extension to
//              64 bits (leading zeros do not disturb the prefix XOR)
//   popcount : number of set bits in a 64-bit vector
// -----------------------------------------------------------------------------
package gray_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // bin[i] is the XOR of all Gray bits at or above i, so a running XOR from
    // the MSB down yields the binary word for any width up to 64.
    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        logic        acc;
        acc = 1'b0;
        b   = '0;
        for (int i = 63; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Combinational Gray-to-binary decoder, the mirror of the binary-to-Gray
// converter upstream.
//   gray : W-bit Gray-coded word (input)
//   bin  : W-bit binary decode   (output)
// -----------------------------------------------------------------------------
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [63:0] bin_wide;

    always_comb begin
        bin_wide = gray2bin(64'(gray));
    end

    assign bin = bin_wide[W-1:0];

endmodule

// File: rtl/gray_step_checker.sv
// -----------------------------------------------------------------------------
// gray_step_checker
// Registered downstream stage for a Gray-coded stream. Each accepted word is
// decoded to binary and compared with the previously accepted word: exactly
// one differing bit is a legal +1/-1 step, anything else is a bad step. Bad
// steps are counted (saturating) and MAX_BAD consecutive bad steps raise a
// sticky fault that only clr or rst removes.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : synchronous clear of counters, tracking state and fault
//   in_valid     : gray_in is valid
//   in_ready     : block can accept this cycle
//   gray_in      : W-bit Gray word
//   out_valid    : output registers hold a result
//   out_ready    : consumer takes the result this cycle
//   bin_out      : decoded binary of the result
//   step_ok      : legal single-bit step, or first sample
//   dir_up       : 1 = +1 step, 0 = -1 step (valid when step_ok && !first)
//   first        : first sample after rst or clr
//   err_count    : total bad steps, saturating at 2^CW-1
//   fault        : sticky consecutive-bad-step fault
// -----------------------------------------------------------------------------
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int W       = 4,
    parameter int CW      = 8,
    parameter int MAX_BAD = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  gray_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  bin_out,
    output logic          step_ok,
    output logic          dir_up,
    output logic          first,
    output logic [CW-1:0] err_count,
    output logic          fault
);

    localparam logic [7:0] MAX_BAD_L = 8'(MAX_BAD);

    state_t       state;
    logic [W-1:0] prev_gray;
    logic [W-1:0] prev_bin;
    logic [7:0]   bad_run;

    // ---- stage p0: decode and step classification of the incoming word ----
    logic         vld_p0;
    logic [W-1:0] bin_p0;
    logic [6:0]   dist_p0;
    logic         legal_p0;
    logic         up_p0;
    logic [7:0]   bad_nx_p0;

    gray_to_binary #(.W(W)) u_dec (
        .gray (gray_in),
        .bin  (bin_p0)
    );

    // One-entry output register: a new word may enter whenever the slot is
    // empty or is being drained on this same edge.
    assign in_ready  = !out_valid || out_ready;
    assign vld_p0    = in_valid && in_ready;

    assign dist_p0   = popcount(64'(gray_in ^ prev_gray));
    assign legal_p0  = (dist_p0 == 7'd1);
    assign up_p0     = (bin_p0 == prev_bin + W'(1));
    assign bad_nx_p0 = (bad_run == 8'hFF) ? bad_run : bad_run + 8'd1;

    // ---- stage p1: result registers, tracking state and counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            step_ok   <= 1'b0;
            dir_up    <= 1'b0;
            first     <= 1'b0;
            err_count <= '0;
            fault     <= 1'b0;
            bad_run   <= '0;
            state     <= EMPTY;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // clr alone keeps any pending result; it only forgets history.
            if (clr && !vld_p0) begin
                err_count <= '0;
                bad_run   <= '0;
                fault     <= 1'b0;
                state     <= EMPTY;
            end

            if (vld_p0) begin
                out_valid <= 1'b1;
                bin_out   <= bin_p0;
                if (clr || state == EMPTY) begin
                    // No reference yet (or clr alongside this word): take it
                    // as the new starting point without a comparison.
                    first     <= 1'b1;
                    step_ok   <= 1'b1;
                    dir_up    <= 1'b0;
                    err_count <= '0;
                    bad_run   <= '0;
                    fault     <= 1'b0;
                    state     <= TRACK;
                end else begin
                    first <= 1'b0;
                    if (legal_p0) begin
                        step_ok <= 1'b1;
                        dir_up  <= up_p0;
                        bad_run <= '0;
                    end else begin
                        step_ok <= 1'b0;
                        dir_up  <= 1'b0;
                        if (err_count != {CW{1'b1}}) begin
                            err_count <= err_count + CW'(1);
                        end
                        bad_run <= bad_nx_p0;
                        if (bad_nx_p0 >= MAX_BAD_L) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end
                    end
                end
            end
        end
    end

    // Reference word: updated on every accept, bad samples included. Only
    // read once a reference exists, so it carries no reset.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            prev_gray <= gray_in;
            prev_bin  <= bin_p0;
        end
    end

endmodule

// File: tb/tb_gray_step_checker.sv
// -----------------------------------------------------------------------------
// tb_gray_step_checker
// Directed and randomized bench for gray_step_checker (W=4, MAX_BAD=3).
// Two instances share the stimulus: one with CW=8 and one with CW=2, so the
// saturating error counter is observed at both widths.
// -----------------------------------------------------------------------------
module tb_gray_step_checker;

    localparam int W       = 4;
    localparam int MAX_BAD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] gray_in = 4'd0;

    logic       in_ready, out_valid, step_ok, dir_up, first, fault;
    logic [3:0] bin_out;
    logic [7:0] err_count;

    logic       in_ready_s, out_valid_s, step_ok_s, dir_up_s, first_s, fault_s;
    logic [3:0] bin_out_s;
    logic [1:0] err_count_s;

    gray_step_checker #(.W(W), .CW(8), .MAX_BAD(MAX_BAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .step_ok   (step_ok),
        .dir_up    (dir_up),
        .first     (first),
        .err_count (err_count),
        .fault     (fault)
    );

    gray_step_checker #(.W(W), .CW(2), .MAX_BAD(MAX_BAD)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .gray_in   (gray_in),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .bin_out   (bin_out_s),
        .step_ok   (step_ok_s),
        .dir_up    (dir_up_s),
        .first     (first_s),
        .err_count (err_count_s),
        .fault     (fault_s)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_has_ref;
    int m_prev_g, m_prev_b, m_bad, m_err;
    bit m_fault;
    bit e_valid, e_ok, e_up, e_first;
    int e_bin;

    // Inverse of b ^ (b >> 1) found by search over all 4-bit values.
    function automatic int g2b(input int g);
        for (int b = 0; b < 16; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_has_ref = 1'b0;
        m_prev_g  = 0;
        m_prev_b  = 0;
        m_bad     = 0;
        m_err     = 0;
        m_fault   = 1'b0;
        e_valid   = 1'b0;
        e_ok      = 1'b0;
        e_up      = 1'b0;
        e_first   = 1'b0;
        e_bin     = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_valid"},   out_valid,   e_valid);
        chk({tag, ":out_valid_s"}, out_valid_s, e_valid);
        if (e_valid) begin
            chk({tag, ":bin_out"},   bin_out,   e_bin);
            chk({tag, ":bin_out_s"}, bin_out_s, e_bin);
            chk({tag, ":step_ok"},   step_ok,   e_ok);
            chk({tag, ":step_ok_s"}, step_ok_s, e_ok);
            chk({tag, ":first"},     first,     e_first);
            chk({tag, ":first_s"},   first_s,   e_first);
            if (e_ok && !e_first) begin
                chk({tag, ":dir_up"},   dir_up,   e_up);
                chk({tag, ":dir_up_s"}, dir_up_s, e_up);
            end
        end
        chk({tag, ":err_count"},   err_count,   sat(m_err, 255));
        chk({tag, ":err_count_s"}, err_count_s, sat(m_err, 3));
        chk({tag, ":fault"},       fault,       m_fault);
        chk({tag, ":fault_s"},     fault_s,     m_fault);
    endtask

    // One clock cycle: drive after the falling edge, check readiness before
    // the rising edge, advance the model and check results after it.
    task automatic step(input bit iv, input int g, input bit ordy, input bit c,
                        input string tag);
        bit rdy, acc;
        int b;
        @(negedge clk);
        in_valid  = iv;
        gray_in   = 4'(g);
        out_ready = ordy;
        clr       = c;
        #1;
        rdy = !e_valid || ordy;
        chk({tag, ":in_ready"},   in_ready,   rdy);
        chk({tag, ":in_ready_s"}, in_ready_s, rdy);
        acc = iv && rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            b = g2b(g);
            if (c || !m_has_ref) begin
                e_first   = 1'b1;
                e_ok      = 1'b1;
                e_up      = 1'b0;
                m_err     = 0;
                m_bad     = 0;
                m_fault   = 1'b0;
                m_has_ref = 1'b1;
            end else begin
                e_first = 1'b0;
                if ($countones(4'(g ^ m_prev_g)) == 1) begin
                    e_ok  = 1'b1;
                    e_up  = (((b - m_prev_b) & 15) == 1);
                    m_bad = 0;
                end else begin
                    e_ok = 1'b0;
                    m_err++;
                    m_bad++;
                    if (m_bad >= MAX_BAD) m_fault = 1'b1;
                end
            end
            m_prev_g = g;
            m_prev_b = b;
            e_valid  = 1'b1;
            e_bin    = b;
        end else begin
            if (ordy) e_valid = 1'b0;
            if (c) begin
                m_err     = 0;
                m_bad     = 0;
                m_fault   = 1'b0;
                m_has_ref = 1'b0;
            end
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk({tag, ":out_valid"}, out_valid, 0);
        chk({tag, ":bin_out"},   bin_out,   0);
        chk({tag, ":step_ok"},   step_ok,   0);
        chk({tag, ":dir_up"},    dir_up,    0);
        chk({tag, ":first"},     first,     0);
        chk({tag, ":err_count"}, err_count, 0);
        chk({tag, ":fault"},     fault,     0);
        chk({tag, ":in_ready"},  in_ready,  1);
        chk({tag, ":fault_s"},   fault_s,   0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r, g;
        bit iv, ordy, c;

        model_reset();
        do_reset("rst0");

        // Counting sequence 0,1,2,3
        step(1, 4'b0000, 1, 0, "seq0");
        chk("seq0_first", first, 1);
        step(1, 4'b0001, 1, 0, "seq1");
        step(1, 4'b0011, 1, 0, "seq2");
        step(1, 4'b0010, 1, 0, "seq3");
        chk("seq3_bin", bin_out, 3);
        chk("seq3_dir", dir_up, 1);
        chk("seq3_err", err_count, 0);

        // Wrap through 15 -> 0 and back down, restarted with clr
        step(1, 4'b1001, 1, 1, "wrap14");
        step(1, 4'b1000, 1, 0, "wrap15");
        step(1, 4'b0000, 1, 0, "wrap0");
        chk("wrap0_dir", dir_up, 1);
        step(1, 4'b1000, 1, 0, "wrapdn");
        chk("wrapdn_bin", bin_out, 15);
        chk("wrapdn_dir", dir_up, 0);

        // Three bad steps (distance 2, repeat, distance 2) into FAULT
        step(1, 4'b0000, 1, 1, "bad0");
        step(1, 4'b0011, 1, 0, "bad1");
        step(1, 4'b0011, 1, 0, "bad2");
        step(1, 4'b0110, 1, 0, "bad3");
        chk("bad3_err", err_count, 3);
        chk("bad3_fault", fault, 1);
        step(1, 4'b0111, 1, 0, "legal_in_fault");
        chk("legal_in_fault_keep", fault, 1);

        // Back-pressure with a pending result, then release
        step(1, 4'b0101, 0, 0, "bp0");
        step(1, 4'b1111, 0, 0, "bp1");
        step(1, 4'b0101, 0, 0, "bp2");
        chk("bp_ready", in_ready, 0);
        chk("bp_err", err_count, 3);
        step(1, 4'b0101, 1, 0, "bp_rel0");
        step(1, 4'b0100, 1, 0, "bp_rel1");
        chk("bp_rel1_bin", bin_out, 7);

        // clr together with an accept while faulted
        step(1, 4'b1100, 1, 1, "clr_acc");
        chk("clr_acc_fault", fault, 0);
        chk("clr_acc_err", err_count, 0);
        chk("clr_acc_first", first, 1);

        // Five repeats: the CW=2 counter stops at 3
        for (int i = 0; i < 5; i++) step(1, 4'b1100, 1, 0, "sat");
        chk("sat_err8", err_count, 5);
        chk("sat_err2", err_count_s, 3);

        // clr alone keeps the pending result; next accept is a first sample
        step(1, 4'b1101, 0, 0, "clr_pend");
        step(0, 4'b0000, 0, 1, "clr_hold");
        chk("clr_hold_valid", out_valid, 1);
        step(1, 4'b0110, 1, 0, "clr_next");
        chk("clr_next_first", first, 1);

        // Randomized traffic, mostly legal steps
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 40) == 0);
            r    = $urandom_range(0, 9);
            if (r < 4)       g = b2g((m_prev_b + 1) & 15);
            else if (r < 7)  g = b2g((m_prev_b + 15) & 15);
            else if (r == 7) g = m_prev_g;
            else             g = $urandom_range(0, 15);
            step(iv, g, ordy, c, "rnd");
        end

        // Reset with a result pending
        step(1, b2g((m_prev_b + 1) & 15), 0, 0, "pre_rst");
        do_reset("rst_mid");
        step(1, 4'b0110, 1, 0, "post_rst");
        chk("post_rst_first", first, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
